// File: rtl/facedet_pkg.sv
// Shared types and helpers for the face-detection tile dispatcher.
package facedet_pkg;

    localparam int DEF_NUM_CORES = 32;
    localparam int DEF_TILE_W    = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        WAIT     = 2'd2,
        FINISH   = 2'd3
    } state_t;

    // Wide enough for any supported core count (up to 64).
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/facedet_sched_rr_arbiter.sv
// Round-robin picker: lowest requesting index at or after the pointer, wrapping.
module rr_arbiter
    import facedet_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES
) (
    input  logic [NUM_CORES-1:0]         i_req,
    input  logic [$clog2(NUM_CORES)-1:0] i_ptr,
    output logic [NUM_CORES-1:0]         o_grant,
    output logic                         o_valid
);

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            int idx;
            idx = int'(i_ptr) + k;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (!o_valid && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/facedet_sched.sv
// Tile dispatcher: launches one tile per cycle onto idle cores, retires on core_done,
// and pulses frame_done once every tile of the frame has been retired.
//
// state    | meaning
// IDLE     | waiting for start
// DISPATCH | handing out tiles, one per cycle while an idle core exists
// WAIT     | all tiles launched, waiting for the last retirements
// FINISH   | one-cycle frame_done
module facedet_sched
    import facedet_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int TILE_W    = DEF_TILE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [TILE_W-1:0]    num_tiles,
    output logic [NUM_CORES-1:0] core_start,
    output logic [TILE_W-1:0]    core_tile,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NUM_CORES-1:0] cores_busy,
    output logic [TILE_W-1:0]    tiles_done,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_spurious
);

    localparam int PTR_W = $clog2(NUM_CORES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TILE_W-1:0]    r_count;
    logic [TILE_W-1:0]    r_next_tile;
    logic [TILE_W-1:0]    r_tiles_done;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [NUM_CORES-1:0] r_busy_mask;
    logic [NUM_CORES-1:0] r_core_start;
    logic [TILE_W-1:0]    r_core_tile;
    logic                 r_err;
    logic [NUM_CORES-1:0] w_gnt;
    logic                 w_gnt_valid;
    logic                 w_dispatch;
    logic                 w_accept;
    logic [NUM_CORES-1:0] w_retire;
    logic [TILE_W-1:0]    w_retire_cnt;

    rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .i_req   (~r_busy_mask),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_valid (w_gnt_valid)
    );

    assign w_accept     = (r_state == IDLE) && start;
    assign w_retire     = core_done & r_busy_mask;
    assign w_retire_cnt = TILE_W'(popcount(64'(w_retire)));

    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_gnt[i]) begin
                w_ptr_nxt = (i == NUM_CORES - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dispatch  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_tiles == '0) ? WAIT : DISPATCH;
                end
            end
            DISPATCH: begin
                w_dispatch = w_gnt_valid;
                if (w_gnt_valid && ((r_next_tile + TILE_W'(1)) == r_count)) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_tiles_done == r_count) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A granted core is never busy and a retired core always is, so the two updates never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= '0;
            r_next_tile  <= '0;
            r_tiles_done <= '0;
            r_ptr        <= '0;
            r_busy_mask  <= '0;
            r_core_start <= '0;
            r_core_tile  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_busy_mask  <= (r_busy_mask & ~core_done) | (w_dispatch ? w_gnt : '0);
            r_core_start <= w_dispatch ? w_gnt : '0;
            r_core_tile  <= w_dispatch ? r_next_tile : '0;
            if (|(core_done & ~r_busy_mask)) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_count      <= num_tiles;
                r_next_tile  <= '0;
                r_tiles_done <= '0;
            end else begin
                r_tiles_done <= r_tiles_done + w_retire_cnt;
                if (w_dispatch) begin
                    r_next_tile <= r_next_tile + TILE_W'(1);
                    r_ptr       <= w_ptr_nxt;
                end
            end
        end
    end

    assign core_start   = r_core_start;
    assign core_tile    = r_core_tile;
    assign cores_busy   = r_busy_mask;
    assign tiles_done   = r_tiles_done;
    assign busy         = (r_state != IDLE);
    assign frame_done   = (r_state == FINISH);
    assign err_spurious = r_err;

endmodule

// File: tb/tb_facedet_sched.sv
// Directed bench for facedet_sched (4 cores) with a per-cycle reference model.
module tb_facedet_sched;

    localparam int NC = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [TW-1:0] num_tiles;
    logic [NC-1:0] core_start;
    logic [TW-1:0] core_tile;
    logic [NC-1:0] core_done;
    logic [NC-1:0] cores_busy;
    logic [TW-1:0] tiles_done;
    logic          busy;
    logic          frame_done;
    logic          err_spurious;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    facedet_sched #(.NUM_CORES(NC), .TILE_W(TW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_tiles    (num_tiles),
        .core_start   (core_start),
        .core_tile    (core_tile),
        .core_done    (core_done),
        .cores_busy   (cores_busy),
        .tiles_done   (tiles_done),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 launching, 2 draining, 3 completion cycle.
    int            m_mode, m_ptr, m_next, m_count, m_tiles;
    bit            m_err;
    bit            m_busy [NC];
    logic [NC-1:0] e_cs;
    logic [TW-1:0] e_tile;

    always @(posedge clk) begin : model
        int g;
        int ndone;
        int c;
        if (reset) begin
            m_mode = 0; m_ptr = 0; m_next = 0; m_count = 0; m_tiles = 0; m_err = 0;
            for (int i = 0; i < NC; i++) m_busy[i] = 0;
            e_cs = '0; e_tile = '0;
        end else begin
            g = -1;
            if (m_mode == 1) begin
                for (int k = 0; k < NC; k++) begin
                    c = (m_ptr + k) % NC;
                    if (g < 0 && !m_busy[c]) g = c;
                end
            end
            ndone = 0;
            for (int i = 0; i < NC; i++) begin
                if (core_done[i]) begin
                    if (m_busy[i]) begin
                        m_busy[i] = 0;
                        ndone++;
                    end else begin
                        m_err = 1;
                    end
                end
            end
            e_cs = '0; e_tile = '0;
            case (m_mode)
                0: begin
                    if (start) begin
                        m_count = int'(num_tiles); m_next = 0; m_tiles = 0;
                        m_mode = (num_tiles == 0) ? 2 : 1;
                    end else begin
                        m_tiles += ndone;
                    end
                end
                1: begin
                    m_tiles += ndone;
                    if (g >= 0) begin
                        e_cs[g] = 1'b1;
                        e_tile  = TW'(m_next);
                        m_busy[g] = 1;
                        m_next++;
                        m_ptr = (g + 1) % NC;
                        if (m_next == m_count) m_mode = 2;
                    end
                end
                2: begin
                    if (m_tiles == m_count) m_mode = 3;
                    m_tiles += ndone;
                end
                default: begin
                    m_tiles += ndone;
                    m_mode = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin : compare
        logic [NC-1:0] eb;
        if (chk_en) begin
            for (int i = 0; i < NC; i++) eb[i] = m_busy[i];
            check("m_core_start", 64'(core_start), 64'(e_cs));
            if (e_cs != '0) check("m_core_tile", 64'(core_tile), 64'(e_tile));
            check("m_cores_busy", 64'(cores_busy), 64'(eb));
            check("m_tiles_done", 64'(tiles_done), 64'(m_tiles));
            check("m_busy", 64'(busy), 64'(m_mode != 0));
            check("m_frame_done", 64'(frame_done), 64'(m_mode == 3));
            check("m_err", 64'(err_spurious), 64'(m_err));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int fd_cnt;
        bit cs_seen;
        reset = 1'b1; start = 1'b0; num_tiles = '0; core_done = '0;
        step(); step();
        chk_en = 1'b1;
        check("rst_core_start", 64'(core_start), 64'd0);
        check("rst_cores_busy", 64'(cores_busy), 64'd0);
        check("rst_tiles_done", 64'(tiles_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_err", 64'(err_spurious), 64'd0);
        reset = 1'b0;

        // basic frame: 3 tiles
        start = 1'b1; num_tiles = 16'd3; step(); start = 1'b0;
        check("basic_busy", 64'(busy), 64'd1);
        check("basic_cs_k", 64'(core_start), 64'd0);
        step(); check("basic_cs0", 64'(core_start), 64'h1); check("basic_t0", 64'(core_tile), 64'd0);
        step(); check("basic_cs1", 64'(core_start), 64'h2); check("basic_t1", 64'(core_tile), 64'd1);
        step(); check("basic_cs2", 64'(core_start), 64'h4); check("basic_t2", 64'(core_tile), 64'd2);
        step(); check("basic_idle_cs", 64'(core_start), 64'd0); check("basic_mask", 64'(cores_busy), 64'h7);
        core_done = 4'b0001; step();
        core_done = 4'b0010; step();
        core_done = 4'b0100; step(); core_done = '0;
        check("basic_tiles3", 64'(tiles_done), 64'd3);
        check("basic_fd_early", 64'(frame_done), 64'd0);
        step(); check("basic_fd", 64'(frame_done), 64'd1); check("basic_tiles_fd", 64'(tiles_done), 64'd3);
        step(); check("basic_fd_off", 64'(frame_done), 64'd0); check("basic_idle", 64'(busy), 64'd0);

        // saturation and wrap: 6 tiles on 4 cores
        reset = 1'b1; step(); reset = 1'b0;
        start = 1'b1; num_tiles = 16'd6; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("sat_cs", 64'(core_start), 64'(1 << i));
            check("sat_tile", 64'(core_tile), 64'(i));
        end
        step(); check("sat_stall", 64'(core_start), 64'd0); check("sat_full", 64'(cores_busy), 64'hF);
        step(); check("sat_stall2", 64'(core_start), 64'd0);
        core_done = 4'b0010; step(); core_done = '0;
        check("sat_ret1_cs", 64'(core_start), 64'd0); check("sat_ret1_mask", 64'(cores_busy), 64'hD);
        step(); check("sat_re1_cs", 64'(core_start), 64'h2); check("sat_re1_tile", 64'(core_tile), 64'd4);
        core_done = 4'b0001; step(); core_done = '0;
        check("sat_ret0_cs", 64'(core_start), 64'd0);
        step(); check("sat_wrap_cs", 64'(core_start), 64'h1); check("sat_wrap_tile", 64'(core_tile), 64'd5);
        check("sat_tiles2", 64'(tiles_done), 64'd2);

        // simultaneous dones
        core_done = 4'b1111; step(); core_done = '0;
        check("sim_tiles", 64'(tiles_done), 64'd6); check("sim_mask", 64'(cores_busy), 64'd0);
        step(); check("sim_fd", 64'(frame_done), 64'd1);
        step();

        // spurious done while idle
        core_done = 4'b0100; step(); core_done = '0;
        check("spur_err", 64'(err_spurious), 64'd1); check("spur_tiles", 64'(tiles_done), 64'd6);

        // zero-tile frame
        start = 1'b1; num_tiles = 16'd0; step(); start = 1'b0;
        fd_cnt = 0; cs_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            fd_cnt += int'(frame_done);
            cs_seen |= |core_start;
        end
        check("zero_fd_once", 64'(fd_cnt), 64'd1);
        check("zero_no_cs", 64'(cs_seen), 64'd0);
        check("zero_idle", 64'(busy), 64'd0);

        // start during DISPATCH is ignored; pointer resumes at core 1
        start = 1'b1; num_tiles = 16'd3; step();
        start = 1'b1; num_tiles = 16'd9; step(); start = 1'b0;
        check("ign_cs0", 64'(core_start), 64'h2); check("ign_t0", 64'(core_tile), 64'd0);
        step(); check("ign_cs1", 64'(core_start), 64'h4); check("ign_t1", 64'(core_tile), 64'd1);
        step(); check("ign_cs2", 64'(core_start), 64'h8); check("ign_t2", 64'(core_tile), 64'd2);
        step(); check("ign_stop", 64'(core_start), 64'd0);
        core_done = 4'b1110; step(); core_done = '0;
        check("ign_tiles", 64'(tiles_done), 64'd3);
        step(); check("ign_fd", 64'(frame_done), 64'd1);
        step();

        // reset mid-frame
        start = 1'b1; num_tiles = 16'd5; step(); start = 1'b0;
        step(); step();
        check("mid_mask_pre", 64'(cores_busy), 64'h3);
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_cs", 64'(core_start), 64'd0);
        check("mid_tile", 64'(core_tile), 64'd0);
        check("mid_mask", 64'(cores_busy), 64'd0);
        check("mid_tiles", 64'(tiles_done), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_fd", 64'(frame_done), 64'd0);
        check("mid_err", 64'(err_spurious), 64'd0);
        core_done = 4'b0010; step(); core_done = '0;
        check("mid_forgot_err", 64'(err_spurious), 64'd1);
        check("mid_forgot_tiles", 64'(tiles_done), 64'd0);
        start = 1'b1; num_tiles = 16'd2; step(); start = 1'b0;
        step(); check("fresh_cs0", 64'(core_start), 64'h1); check("fresh_t0", 64'(core_tile), 64'd0);
        step(); check("fresh_cs1", 64'(core_start), 64'h2); check("fresh_t1", 64'(core_tile), 64'd1);
        core_done = 4'b0011; step(); core_done = '0;
        check("fresh_tiles", 64'(tiles_done), 64'd2);
        step(); check("fresh_fd", 64'(frame_done), 64'd1);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/facedet_sched.md
# facedet_sched

Tile dispatcher for the many-core face-detection array. Given a frame split into `num_tiles` tiles, it hands each tile index to an idle detection core, tracks per-core busy state from start/done handshakes, and raises a single completion pulse once every tile has been processed. It sits between the frame loader and the bank of detection cores, and it owns the only start path into those cores.

## Interface
- `NUM_CORES`, default 32: number of detection cores. Must be 2..64.
- `TILE_W`, default 16: width of the tile-index and tile-count fields.
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high. Sampled on `clk` only.
- `start`, input, 1: one-cycle frame start request. Ignored unless the block is in IDLE.
- `num_tiles`, input, TILE_W: tiles in the frame. Captured when `start` is accepted.
- `core_start`, output, NUM_CORES: one-hot, one-cycle launch pulse.
- `core_tile`, output, TILE_W: tile index for the core being launched. Valid only while `core_start` is nonzero.
- `core_done`, input, NUM_CORES: per-core one-cycle completion pulses. Any number of bits may be high in the same cycle.
- `cores_busy`, output, NUM_CORES: busy mask, one bit per core.
- `tiles_done`, output, TILE_W: count of tiles retired in the current frame.
- `busy`, output, 1: high whenever the state is not IDLE.
- `frame_done`, output, 1: one-cycle pulse when the frame completes.
- `err_spurious`, output, 1: sticky flag, set by a `core_done` pulse on a core that is not busy.

## Operation
- **Reset values.** Every output is 0. The state is IDLE. The next-tile counter, the round-robin pointer and the captured count are all 0.
- **IDLE.** When `start` is sampled, capture `num_tiles`, clear `tiles_done` and the next-tile counter, then go to DISPATCH. `err_spurious` is cleared only by `reset`.
- **DISPATCH.** Runs while next-tile < captured count.
  - Each cycle, grant at most one core: the lowest-numbered idle core at or after the RR pointer, wrapping past NUM_CORES-1 back to 0.
  - On a grant to core g:
    - `core_start[g]` is 1 and `core_tile` = next-tile.
    - `cores_busy[g]` is set.
    - next-tile increments.
    - The pointer moves to (g+1) mod NUM_CORES.
  - If every core is busy, nothing is granted and state is held.
  - When next-tile reaches the captured count, go to WAIT.
- **WAIT.** Go to FINISH when `tiles_done` equals the captured count.
- **FINISH.** `frame_done` is 1 for exactly this one cycle, then return to IDLE.
- **Retirement.** Runs in every state.
  - Each `core_done[i]` with `cores_busy[i]`=1 clears that busy bit and adds 1 to `tiles_done`.
  - Several retirements in the same cycle add their popcount.
- **Spurious done.** A `core_done[i]` with `cores_busy[i]`=0 sets `err_spurious` and is otherwise ignored: no count change.
- **Zero-tile frame.** A `start` with `num_tiles`=0 goes from IDLE to WAIT, then FINISH. No `core_start` is issued.
- **Arithmetic.** `tiles_done` and next-tile are unsigned TILE_W counters. They cannot overflow, because both stop at the captured count.

## Timing
- **Start acceptance.** `start` sampled at edge k → `busy`=1 and state DISPATCH after edge k. The first `core_start` is visible in cycle k+1 (registered output).
- **Dispatch throughput.** One launch per cycle while idle cores exist. N tiles on ≥N idle cores take N consecutive `core_start` cycles.
- **Core reuse.**
  - A core retired at edge t can be granted from cycle t+1. It is never granted in the same cycle its `core_done` is sampled.
  - A core cannot receive `core_done` in the cycle it is being started. If that occurs, the done counts as spurious.
- **Completion latency.** The last retirement sampled at edge t → FINISH in cycle t+1. A WAIT cycle is inserted if DISPATCH has not yet exited.
- **Start while busy.** `start` is ignored.
- **Reset mid-frame.**
  - All state and outputs clear on the next edge.
  - Busy cores are forgotten. Their later `core_done` pulses are flagged as spurious.

## Structure
- Shared package `facedet_pkg` holds:
  - the state enum {IDLE, DISPATCH, WAIT, FINISH};
  - the NUM_CORES and TILE_W defaults;
  - a popcount function.
- Sub-module `rr_arbiter`:
  - inputs: request mask (~cores_busy) and pointer;
  - outputs: one-hot grant and a valid flag;
  - purely combinational, parameterised by NUM_CORES.
- The top level holds the FSM, the counters, the busy mask and the output registers.

## Test plan
- **Basic frame.** Use NUM_CORES=4. Assert `start` with `num_tiles`=3 while the cores never finish. Required: `core_start` = 0001, 0010, 0100 on cycles k+1..k+3 with `core_tile` = 0, 1, 2. Then return all three dones. Required: `frame_done` one cycle after the last done, with `tiles_done`=3.
- **Saturation and wrap.** Use NUM_CORES=4 with `num_tiles`=6. After 4 launches, stall. Pulse `core_done[1]`. Required: the next launch goes to core 1 with tile 4, one cycle later. Then pulse `core_done[0]`. Required: tile 5 goes to core 0, wrapping from pointer 2.
- **Simultaneous dones.** Pulse `core_done`=1111 in one cycle. Required: `tiles_done` increases by 4 and `cores_busy`=0000 on the next cycle.
- **Zero tiles.** Assert `start` with `num_tiles`=0. Required: no `core_start`, and `frame_done` pulses exactly once within 3 cycles.
- **Spurious and ignored start.**
  - Pulse `core_done[2]` while IDLE. Required: `err_spurious`=1 and `tiles_done` unchanged.
  - Pulse `start` during DISPATCH. Required: no effect on the count or on the tile sequence.
- **Reset mid-frame.** Assert `reset` during DISPATCH. Required: all outputs are 0 on the next cycle, and a fresh `start` re-launches from core 0 with tile 0.
